ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised multi-cycle instruction sequencer for the 8-bit CPU. It decodes an opcode of configurable width into datapath strobes. Instruction fetch, LOAD and STORE wait on a `mem_ready` handshake, so wait-stated memory is supported. It adds a conditional jump (JZ), a terminal HALT state and an optional wait-state timeout. It sits between the instruction register/flags and the PC, register file, ALU and memory port.

## Interface
- `OPW`, 4: opcode width in bits.
- `ALUW`, 3: `alu_op` width in bits; must satisfy `ALUW <= OPW`.
- `NUM_ALU`, 5: opcodes `0..NUM_ALU-1` are ALU operations.
- `OP_LOAD` 5, `OP_STORE` 6, `OP_JMP` 7, `OP_JZ` 8, `OP_HALT` 15: fixed opcode codes. Any other opcode is a NOP.
- `MAX_WAIT`, 15: timeout limit, in wait cycles.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `opcode`, in, OPW: opcode from the IR, stable from DECODE onward.
- `zero_flag`, in, 1: ALU zero flag, sampled in EXEC.
- `mem_ready`, in, 1: memory completes the current access this cycle.
- `pc_en`, `pc_load`, `ir_load`, `reg_write`, `mem_read`, `mem_write`, out, 1 each: datapath strobes.
- `alu_op`, out, ALUW: ALU operation select.
- `halted`, out, 1: high while in the HALT state.
- `bus_err`, out, 1: sticky flag; a memory wait timed out.
- `state_o`, out, 3: current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4.
- Every output defaults to 0 in every state unless listed below.
- FETCH:
  - `mem_read=1`.
  - When `mem_ready=1`: `ir_load=1`, `pc_en=1` (Mealy on `mem_ready`), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: go to EXEC.
- EXEC, behaviour by opcode:
  - ALU op: `alu_op=opcode[ALUW-1:0]`, go to WB.
  - LOAD: `mem_read=1` until `mem_ready`, then go to WB.
  - STORE: `mem_write=1` until `mem_ready`, then go to FETCH.
  - JMP: `pc_en=1`, `pc_load=1`, go to FETCH.
  - JZ with `zero_flag=1`: same as JMP.
  - JZ with `zero_flag=0`: no strobes, go to FETCH.
  - HALT: go to HALT.
  - NOP: go to FETCH.
- WB: `reg_write=1`, go to FETCH. During an ALU writeback, `alu_op` is held at the opcode value.
- HALT: `halted=1`. The block stays in HALT until `rst`, with all strobes 0.
- Wait counter (`WAITW=$clog2(MAX_WAIT+1)` bits):
  - Clears on every state change and whenever `mem_ready=1`.
  - Increments for each cycle spent waiting in FETCH, LOAD-EXEC or STORE-EXEC.
  - Saturates at `MAX_WAIT`.
- Reset:
  - State returns to FETCH; the counter, `bus_err` and `halted` clear.
  - While `rst=1`, every output is forced to 0, including `mem_read`.
  - Reset asserted mid-instruction aborts it immediately, with no partial strobes.

## Timing
- Latencies with zero wait states (`mem_ready` held at 1):
  - ALU op and LOAD: 4 cycles.
  - STORE, JMP and taken JZ: 3 cycles.
  - Not-taken JZ and NOP: 3 cycles.
- Each wait cycle adds 1 cycle of latency.
- `mem_read` and `mem_write` are held steady from the first cycle of an access through the cycle in which `mem_ready=1`.
- `mem_ready` is ignored in every state other than FETCH and LOAD/STORE EXEC.
- `pc_en` and `ir_load` pulse for exactly 1 cycle per fetch.
- `pc_load` is asserted only together with `pc_en`.

## Configuration
- Macro: `CTRL_WAIT_TIMEOUT_EN`.
- Defined:
  - When the counter reaches `MAX_WAIT` with `mem_ready=0`, the next edge sets `bus_err=1` and enters HALT.
  - The strobes drop in that same edge.
- Undefined:
  - Waits are unbounded.
  - `bus_err` is tied to 0 and the counter is not synthesised.

## Test plan
- `mem_ready=1`, opcode 2: cycle trace FETCH, DECODE, EXEC (`alu_op=2`), WB (`reg_write=1`), FETCH; 4 cycles total.
- LOAD with `mem_ready` low for 3 cycles in EXEC: `mem_read` high for 4 cycles, then `reg_write` pulses once in WB.
- JZ with `zero_flag=1`: `pc_en=pc_load=1` for 1 cycle. JZ with `zero_flag=0`: no `pc_load`; returns to FETCH after 3 cycles.
- Opcode 15: `halted=1` and stays high for at least 20 cycles with `mem_ready` toggling. After `rst`: `state_o=0`, `halted=0`.
- `CTRL_WAIT_TIMEOUT_EN` defined, `MAX_WAIT=4`, STORE with `mem_ready=0`: `bus_err=1` and HALT entered after the 5th wait edge, `mem_write` drops in the same cycle.
- `rst` pulsed in the middle of a LOAD wait: all outputs 0 while `rst` is asserted; after release, `state_o=0` and the counter is 0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer: decodes the IR opcode into datapath strobes,
// with mem_ready handshakes. Optional wait-state timeout under CTRL_WAIT_TIMEOUT_EN.
module ctrl_sequencer #(
    parameter int OPW      = 4,
    parameter int ALUW     = 3,
    parameter int NUM_ALU  = 5,
    parameter int OP_LOAD  = 5,
    parameter int OP_STORE = 6,
    parameter int OP_JMP   = 7,
    parameter int OP_JZ    = 8,
    parameter int OP_HALT  = 15,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero_flag,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            pc_load,
    output logic            ir_load,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [ALUW-1:0] alu_op,
    output logic            halted,
    output logic            bus_err,
    output logic [2:0]      state_o
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic is_alu, is_load, is_store, is_jmp, is_jz, is_halt;
    logic waiting;
    logic pc_en_c, pc_load_c, ir_load_c, reg_write_c, mem_read_c, mem_write_c;
    logic [ALUW-1:0] alu_op_c;
    logic timeout;

    assign is_alu   = int'(opcode) < NUM_ALU;
    assign is_load  = opcode == OPW'(OP_LOAD);
    assign is_store = opcode == OPW'(OP_STORE);
    assign is_jmp   = opcode == OPW'(OP_JMP);
    assign is_jz    = opcode == OPW'(OP_JZ);
    assign is_halt  = opcode == OPW'(OP_HALT);

    // A cycle counts as a wait only in states that own a memory access
    assign waiting = !mem_ready &&
                     (state == FETCH || (state == EXEC && (is_load || is_store)));

`ifdef CTRL_WAIT_TIMEOUT_EN
    localparam int WAITW = $clog2(MAX_WAIT + 1);
    logic [WAITW-1:0] wait_cnt;
    logic             bus_err_q;

    assign timeout = waiting && (wait_cnt == WAITW'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (timeout)
                bus_err_q <= 1'b1;
            if (state_nxt != state || mem_ready)
                wait_cnt <= '0;
            else if (waiting && wait_cnt != WAITW'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus_err = bus_err_q & ~rst;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        pc_en_c     = 1'b0;
        pc_load_c   = 1'b0;
        ir_load_c   = 1'b0;
        reg_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        alu_op_c    = '0;
        case (state)
            FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_load_c = 1'b1;
                    pc_en_c   = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (is_alu) begin
                    alu_op_c  = opcode[ALUW-1:0];
                    state_nxt = WB;
                end else if (is_load) begin
                    mem_read_c = 1'b1;
                    if (mem_ready) state_nxt = WB;
                end else if (is_store) begin
                    mem_write_c = 1'b1;
                    if (mem_ready) state_nxt = FETCH;
                end else if (is_jmp || (is_jz && zero_flag)) begin
                    pc_en_c   = 1'b1;
                    pc_load_c = 1'b1;
                    state_nxt = FETCH;
                end else if (is_halt) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = FETCH;
                end
            end
            WB: begin
                reg_write_c = 1'b1;
                if (is_alu) alu_op_c = opcode[ALUW-1:0];
                state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
        if (timeout) state_nxt = HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Mealy strobes are combinational, so rst must mask them explicitly
    assign pc_en     = pc_en_c     & ~rst;
    assign pc_load   = pc_load_c   & ~rst;
    assign ir_load   = ir_load_c   & ~rst;
    assign reg_write = reg_write_c & ~rst;
    assign mem_read  = mem_read_c  & ~rst;
    assign mem_write = mem_write_c & ~rst;
    assign alu_op    = rst ? '0 : alu_op_c;
    assign halted    = (state == HALT) & ~rst;
    assign state_o   = rst ? 3'd0 : state;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer; per-cycle output vectors checked against hand-derived values.
module tb_ctrl_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       mem_ready;
    logic       pc_en, pc_load, ir_load, reg_write, mem_read, mem_write, halted, bus_err;
    logic [2:0] alu_op;
    logic [2:0] state_o;
    logic [13:0] outs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_load(pc_load), .ir_load(ir_load), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .halted(halted),
        .bus_err(bus_err), .state_o(state_o)
    );

    // {pc_en,pc_load,ir_load,reg_write,mem_read,mem_write,halted,bus_err, alu_op, state}
    assign outs = {pc_en, pc_load, ir_load, reg_write, mem_read, mem_write, halted, bus_err,
                   alu_op, state_o};

    localparam logic [7:0] S_NONE  = 8'b0000_0000;
    localparam logic [7:0] S_FETCH = 8'b1010_1000;
    localparam logic [7:0] S_FWAIT = 8'b0000_1000;
    localparam logic [7:0] S_RD    = 8'b0000_1000;
    localparam logic [7:0] S_WR    = 8'b0000_0100;
    localparam logic [7:0] S_WB    = 8'b0001_0000;
    localparam logic [7:0] S_JMP   = 8'b1100_0000;
    localparam logic [7:0] S_HALT  = 8'b0000_0010;
    localparam logic [7:0] S_BERR  = 8'b0000_0011;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already set: check outputs, then advance one cycle
    task automatic cyc(input string tag, input logic [7:0] s, input logic [2:0] a,
                       input logic [2:0] st);
        #1;
        chk(tag, 32'(outs), 32'({s, a, st}));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; opcode = 4'd2; zero_flag = 1'b0; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        cyc("reset_all_zero", S_NONE, 3'd0, 3'd0);
        rst = 1'b0;

        // ALU op 2: four cycles back to FETCH
        cyc("alu_fetch", S_FETCH, 3'd0, 3'd0);
        cyc("alu_decode", S_NONE, 3'd0, 3'd1);
        cyc("alu_exec", S_NONE, 3'd2, 3'd2);
        cyc("alu_wb", S_WB, 3'd2, 3'd3);

        // LOAD with 3 wait cycles in EXEC
        opcode = 4'd5;
        cyc("ld_fetch", S_FETCH, 3'd0, 3'd0);
        cyc("ld_decode", S_NONE, 3'd0, 3'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld_wait", S_RD, 3'd0, 3'd2);
        mem_ready = 1'b1;
        cyc("ld_done", S_RD, 3'd0, 3'd2);
        cyc("ld_wb", S_WB, 3'd0, 3'd3);

        // STORE, zero wait
        opcode = 4'd6;
        cyc("st_fetch", S_FETCH, 3'd0, 3'd0);
        cyc("st_decode", S_NONE, 3'd0, 3'd1);
        cyc("st_exec", S_WR, 3'd0, 3'd2);

        // JMP
        opcode = 4'd7;
        cyc("jmp_fetch", S_FETCH, 3'd0, 3'd0);
        cyc("jmp_decode", S_NONE, 3'd0, 3'd1);
        cyc("jmp_exec", S_JMP, 3'd0, 3'd2);

        // JZ taken / not taken
        opcode = 4'd8; zero_flag = 1'b1;
        cyc("jz1_fetch", S_FETCH, 3'd0, 3'd0);
        cyc("jz1_decode", S_NONE, 3'd0, 3'd1);
        cyc("jz1_exec", S_JMP, 3'd0, 3'd2);
        zero_flag = 1'b0;
        cyc("jz0_fetch", S_FETCH, 3'd0, 3'd0);
        cyc("jz0_decode", S_NONE, 3'd0, 3'd1);
        cyc("jz0_exec", S_NONE, 3'd0, 3'd2);

        // NOP (opcode 9), and mem_ready ignored outside memory states
        opcode = 4'd9;
        cyc("nop_fetch", S_FETCH, 3'd0, 3'd0);
        mem_ready = 1'b0;
        cyc("nop_decode", S_NONE, 3'd0, 3'd1);
        cyc("nop_exec", S_NONE, 3'd0, 3'd2);

        // FETCH wait: mem_read only, no ir_load/pc_en
        cyc("fetch_wait0", S_FWAIT, 3'd0, 3'd0);
        cyc("fetch_wait1", S_FWAIT, 3'd0, 3'd0);
        mem_ready = 1'b1; opcode = 4'd5;
        cyc("fetch_after_wait", S_FETCH, 3'd0, 3'd0);

        // Reset in the middle of a LOAD wait
        cyc("rl_decode", S_NONE, 3'd0, 3'd1);
        mem_ready = 1'b0;
        cyc("rl_wait0", S_RD, 3'd0, 3'd2);
        cyc("rl_wait1", S_RD, 3'd0, 3'd2);
        rst = 1'b1;
        cyc("rl_rst0", S_NONE, 3'd0, 3'd0);
        cyc("rl_rst1", S_NONE, 3'd0, 3'd0);
        rst = 1'b0;
        cyc("rl_after_fwait", S_FWAIT, 3'd0, 3'd0);

        // STORE with memory never ready
        mem_ready = 1'b1; opcode = 4'd6;
        cyc("to_fetch", S_FETCH, 3'd0, 3'd0);
        cyc("to_decode", S_NONE, 3'd0, 3'd1);
        mem_ready = 1'b0;
`ifdef CTRL_WAIT_TIMEOUT_EN
        for (int i = 0; i < 5; i++) cyc("to_wait", S_WR, 3'd0, 3'd2);
        cyc("to_halt_berr", S_BERR, 3'd0, 3'd4);
        mem_ready = 1'b1;
        cyc("to_berr_sticky", S_BERR, 3'd0, 3'd4);
`else
        for (int i = 0; i < 8; i++) cyc("unbounded_wait", S_WR, 3'd0, 3'd2);
        mem_ready = 1'b1;
        cyc("unbounded_done", S_WR, 3'd0, 3'd2);
`endif
        rst = 1'b1;
        cyc("rst2", S_NONE, 3'd0, 3'd0);
        rst = 1'b0;
        cyc("berr_cleared_fetch", S_FETCH, 3'd0, 3'd0);

        // HALT holds through mem_ready toggling
        opcode = 4'd15;
        cyc("rst2_decode", S_NONE, 3'd0, 3'd1);
        cyc("halt_exec", S_NONE, 3'd0, 3'd2);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            cyc("halt_hold", S_HALT, 3'd0, 3'd4);
        end
        rst = 1'b1;
        cyc("halt_rst", S_NONE, 3'd0, 3'd0);
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        chk("halt_released_halted", 32'(halted), 32'd0);
        chk("halt_released_state", 32'(state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
